ex_stage: RTL

- Execute stage of the 16-bit pipeline. Consumes the ID/EX register outputs and resolves operand forwarding.
- Computes the ALU result, including a 17-cycle iterative MUL that stalls upstream.
- Drives the EX/MEM pipeline register, which is internal and owned by this block.
- Outputs feed the MEM stage. Its own EX/MEM contents serve as the EX/MEM forwarding source.

---
 rtl/ex_stage.sv | 291 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage -- execute stage of the 16-bit pipeline.
//
// Resolves operand forwarding (EX/MEM first, then MEM/WB), computes the ALU
// result and owns the EX/MEM pipeline register. MUL is a 17-cycle iterative
// shift-add operation that holds the upstream stages through ex_stall.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   flush                    kill the instruction in EX (aborts a running MUL)
//   ex_*                     ID/EX register contents (controls, operands, indices)
//   wb_reg_write/wb_rd/wb_data  MEM/WB forwarding source
//   ex_stall                 combinational hold request for IF/ID and ID/EX
//   mem_*                    EX/MEM register outputs (feed the MEM stage)
//   dbg_state                MUL FSM state (0 = IDLE, 1 = BUSY)
//   dbg_count                MUL iteration counter
//
// Handshake: there is no valid/ready pair here. ex_stall is the only flow
// control: while it is high the upstream registers must hold, and EX/MEM
// receives a bubble on that edge. When it is low, EX/MEM captures the
// instruction currently in EX on the next rising edge.
// ---------------------------------------------------------------------------
module ex_stage #(
  parameter int DATA_W     = 16,
  parameter int MUL_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_mem_to_reg,
  input  logic              ex_alu_src,
  input  logic [3:0]        ex_alu_op,
  input  logic [1:0]        ex_reg_dst,
  input  logic [DATA_W-1:0] ex_pc,
  input  logic [DATA_W-1:0] ex_reg1_data,
  input  logic [DATA_W-1:0] ex_reg2_data,
  input  logic [2:0]        ex_rs,
  input  logic [2:0]        ex_rt,
  input  logic [2:0]        ex_rd,
  input  logic [5:0]        ex_imm,
  input  logic              wb_reg_write,
  input  logic [2:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_stall,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              mem_mem_to_reg,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [2:0]        mem_rd,
  output logic [DATA_W-1:0] mem_pc,
  output logic              dbg_state,
  output logic [3:0]        dbg_count
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLT   = 4'd5;
  localparam logic [3:0] OP_SLL   = 4'd6;
  localparam logic [3:0] OP_SRL   = 4'd7;
  localparam logic [3:0] OP_SRA   = 4'd8;
  localparam logic [3:0] OP_MUL   = 4'd9;
  localparam logic [3:0] OP_PASSB = 4'd10;

  localparam logic [3:0] LAST_CNT = 4'(MUL_CYCLES - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  // FSM and multiplier state
  state_t              state_q, state_d;
  logic [3:0]          count_q, count_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   rt_q, rt_d;

  // EX/MEM register
  logic                mem_reg_write_q, mem_reg_write_d;
  logic                mem_mem_read_q, mem_mem_read_d;
  logic                mem_mem_write_q, mem_mem_write_d;
  logic                mem_mem_to_reg_q, mem_mem_to_reg_d;
  logic [DATA_W-1:0]   mem_alu_result_q, mem_alu_result_d;
  logic [DATA_W-1:0]   mem_store_data_q, mem_store_data_d;
  logic [2:0]          mem_rd_q, mem_rd_d;
  logic [DATA_W-1:0]   mem_pc_q, mem_pc_d;

  logic [DATA_W-1:0]   fwd_a;
  logic [DATA_W-1:0]   fwd_rt;
  logic [DATA_W-1:0]   op_b;
  logic [DATA_W-1:0]   alu_res;
  logic [DATA_W-1:0]   mul_term;
  logic [DATA_W-1:0]   mul_sum;
  logic [2:0]          dest_rd;
  logic                stall_raw;

  // -------------------------------------------------------------------------
  // Forwarding. r0 is hard-wired to zero, so an r0 source never forwards.
  // EX/MEM is the younger producer and therefore wins over MEM/WB.
  // -------------------------------------------------------------------------
  always_comb begin
    fwd_a = ex_reg1_data;
    if (ex_rs == 3'd0) begin
      fwd_a = '0;
    end else if (mem_reg_write_q && (mem_rd_q != 3'd0) && (mem_rd_q == ex_rs)) begin
      fwd_a = mem_alu_result_q;
    end else if (wb_reg_write && (wb_rd != 3'd0) && (wb_rd == ex_rs)) begin
      fwd_a = wb_data;
    end
  end

  always_comb begin
    fwd_rt = ex_reg2_data;
    if (ex_rt == 3'd0) begin
      fwd_rt = '0;
    end else if (mem_reg_write_q && (mem_rd_q != 3'd0) && (mem_rd_q == ex_rt)) begin
      fwd_rt = mem_alu_result_q;
    end else if (wb_reg_write && (wb_rd != 3'd0) && (wb_rd == ex_rt)) begin
      fwd_rt = wb_data;
    end
  end

  assign op_b = ex_alu_src ? {{(DATA_W-6){ex_imm[5]}}, ex_imm} : fwd_rt;

  // -------------------------------------------------------------------------
  // Single-cycle ALU. MUL yields 0 here; its result comes from the FSM.
  // -------------------------------------------------------------------------
  always_comb begin
    alu_res = '0;
    case (ex_alu_op)
      OP_ADD:   alu_res = fwd_a + op_b;
      OP_SUB:   alu_res = fwd_a - op_b;
      OP_AND:   alu_res = fwd_a & op_b;
      OP_OR:    alu_res = fwd_a | op_b;
      OP_XOR:   alu_res = fwd_a ^ op_b;
      OP_SLT:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
      OP_SLL:   alu_res = fwd_a << op_b[3:0];
      OP_SRL:   alu_res = fwd_a >> op_b[3:0];
      OP_SRA:   alu_res = $signed(fwd_a) >>> op_b[3:0];
      OP_PASSB: alu_res = op_b;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    dest_rd = ex_rt;
    case (ex_reg_dst)
      2'b00:   dest_rd = ex_rt;
      2'b01:   dest_rd = ex_rd;
      2'b10:   dest_rd = 3'd7;
      default: dest_rd = 3'd0;
    endcase
  end

  // One shift-add step on the latched operands; truncation gives mod 2^16.
  assign mul_term = b_q[count_q] ? (a_q << count_q) : '0;
  assign mul_sum  = acc_q + mul_term;

  // -------------------------------------------------------------------------
  // Next-state logic. EX/MEM defaults to a bubble; every edge loads either
  // the instruction in EX or a bubble, so there is no hold path.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d          = state_q;
    count_d          = count_q;
    acc_d            = acc_q;
    a_d              = a_q;
    b_d              = b_q;
    rt_d             = rt_q;
    stall_raw        = 1'b0;
    mem_reg_write_d  = 1'b0;
    mem_mem_read_d   = 1'b0;
    mem_mem_write_d  = 1'b0;
    mem_mem_to_reg_d = 1'b0;
    mem_alu_result_d = '0;
    mem_store_data_d = '0;
    mem_rd_d         = 3'd0;
    mem_pc_d         = '0;

    if (flush) begin
      // Bubble into EX/MEM, abort any MUL, no stall.
      state_d = S_IDLE;
      count_d = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ex_alu_op == OP_MUL) begin
            stall_raw = 1'b1;
            a_d       = fwd_a;
            b_d       = op_b;
            rt_d      = fwd_rt;
            acc_d     = '0;
            count_d   = 4'd0;
            state_d   = S_BUSY;
          end else begin
            mem_reg_write_d  = ex_reg_write;
            mem_mem_read_d   = ex_mem_read;
            mem_mem_write_d  = ex_mem_write;
            mem_mem_to_reg_d = ex_mem_to_reg;
            mem_alu_result_d = alu_res;
            mem_store_data_d = fwd_rt;
            mem_rd_d         = dest_rd;
            mem_pc_d         = ex_pc;
          end
        end
        S_BUSY: begin
          acc_d   = mul_sum;
          count_d = count_q + 4'd1;
          if (count_q == LAST_CNT) begin
            // Final term lands directly in EX/MEM with the MUL's controls,
            // which ID/EX has held steady throughout the stall.
            state_d          = S_IDLE;
            count_d          = 4'd0;
            mem_reg_write_d  = ex_reg_write;
            mem_mem_read_d   = ex_mem_read;
            mem_mem_write_d  = ex_mem_write;
            mem_mem_to_reg_d = ex_mem_to_reg;
            mem_alu_result_d = mul_sum;
            mem_store_data_d = rt_q;
            mem_rd_d         = dest_rd;
            mem_pc_d         = ex_pc;
          end else begin
            stall_raw = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          count_d = 4'd0;
        end
      endcase
    end
  end

  // Reset is asynchronous, so the stall must drop with it, not at the edge.
  assign ex_stall = stall_raw & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_IDLE;
      count_q          <= 4'd0;
      acc_q            <= '0;
      a_q              <= '0;
      b_q              <= '0;
      rt_q             <= '0;
      mem_reg_write_q  <= 1'b0;
      mem_mem_read_q   <= 1'b0;
      mem_mem_write_q  <= 1'b0;
      mem_mem_to_reg_q <= 1'b0;
      mem_alu_result_q <= '0;
      mem_store_data_q <= '0;
      mem_rd_q         <= 3'd0;
      mem_pc_q         <= '0;
    end else begin
      state_q          <= state_d;
      count_q          <= count_d;
      acc_q            <= acc_d;
      a_q              <= a_d;
      b_q              <= b_d;
      rt_q             <= rt_d;
      mem_reg_write_q  <= mem_reg_write_d;
      mem_mem_read_q   <= mem_mem_read_d;
      mem_mem_write_q  <= mem_mem_write_d;
      mem_mem_to_reg_q <= mem_mem_to_reg_d;
      mem_alu_result_q <= mem_alu_result_d;
      mem_store_data_q <= mem_store_data_d;
      mem_rd_q         <= mem_rd_d;
      mem_pc_q         <= mem_pc_d;
    end
  end

  assign mem_reg_write  = mem_reg_write_q;
  assign mem_mem_read   = mem_mem_read_q;
  assign mem_mem_write  = mem_mem_write_q;
  assign mem_mem_to_reg = mem_mem_to_reg_q;
  assign mem_alu_result = mem_alu_result_q;
  assign mem_store_data = mem_store_data_q;
  assign mem_rd         = mem_rd_q;
  assign mem_pc         = mem_pc_q;
  assign dbg_state      = (state_q == S_BUSY);
  assign dbg_count      = count_q;

endmodule
